vblank_write_queue: RTL and testbench

VBLANK_WRITE_QUEUE -- requirements
Module: vblank_write_queue

---
 rtl/vblank_write_queue.sv | 174 +++++++++++++++++
 tb/tb_vblank_write_queue.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vblank_write_queue.sv
// Host-to-VRAM write queue: buffers host writes in a small FIFO and drains them
// to VRAM only while the vblank write window (drain_en) is open.
module vblank_write_queue #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     pixel_clk,
  input  logic                     reset_n,
  input  logic                     drain_en,
  input  logic                     host_cs,
  input  logic [ADDR_W-1:0]        host_addr,
  input  logic [DATA_W-1:0]        host_data,
  output logic                     host_done,
  output logic                     host_write_avail,
  output logic                     vram_cs,
  output logic                     vram_we,
  output logic [ADDR_W-1:0]        vram_addr,
  output logic [DATA_W-1:0]        vram_wdata,
  input  logic                     vram_done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);
  localparam logic [LVL_W-1:0] ZERO_LVL = LVL_W'(0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  rd_next_s;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              acc_q, acc_d;
  logic              done_q, done_d;
  logic              avail_q, avail_d;
  state_e            state_q, state_d;
  logic              vcs_q, vcs_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic [DATA_W-1:0] vdata_q, vdata_d;
  logic              push_s, pop_s;
  logic [ENT_W-1:0]  head_s, next_s;

  // Host side: accept, ignore-until-released tracking, pointers and fill level.
  // Fullness uses the registered level, so a pop cannot make room in the same cycle.
  always_comb begin
    push_s   = host_cs && !acc_q && (level_q < FULL_LVL);
    pop_s    = (state_q == WRITE) && vram_done;
    done_d   = push_s;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      acc_d = 1'b1;
    end else if (!host_cs) begin
      acc_d = 1'b0;
    end else begin
      acc_d = acc_q;
    end
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + ONE_LVL;
      2'b01:   level_d = level_q - ONE_LVL;
      default: level_d = level_q;
    endcase
    avail_d = (level_d < FULL_LVL);
  end

  // Drain FSM next state and next VRAM command
  always_comb begin
    rd_next_s = rd_ptr_q + PTR_W'(1);
    head_s    = mem_q[rd_ptr_q];
    next_s    = mem_q[rd_next_s];
    state_d   = state_q;
    vcs_d     = vcs_q;
    vaddr_d   = vaddr_q;
    vdata_d   = vdata_q;
    case (state_q)
      IDLE: begin
        if (drain_en && (level_q != ZERO_LVL)) begin
          state_d            = WRITE;
          vcs_d              = 1'b1;
          {vaddr_d, vdata_d} = head_s;
        end else begin
          state_d = IDLE;
          vcs_d   = 1'b0;
        end
      end
      WRITE: begin
        if (vram_done) begin
          // Back-to-back only if another entry is already behind the head.
          if (drain_en && (level_q > ONE_LVL)) begin
            state_d            = WRITE;
            vcs_d              = 1'b1;
            {vaddr_d, vdata_d} = next_s;
          end else begin
            state_d = IDLE;
            vcs_d   = 1'b0;
          end
        end else begin
          state_d = WRITE;
          vcs_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        vcs_d   = 1'b0;
      end
    endcase
  end

  // Queue storage
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= {host_addr, host_data};
    end
  end

  // Control state, FSM and registered outputs
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      acc_q    <= 1'b0;
      done_q   <= 1'b0;
      avail_q  <= 1'b1;
      state_q  <= IDLE;
      vcs_q    <= 1'b0;
      vaddr_q  <= '0;
      vdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      avail_q  <= avail_d;
      state_q  <= state_d;
      vcs_q    <= vcs_d;
      vaddr_q  <= vaddr_d;
      vdata_q  <= vdata_d;
    end
  end

  assign host_done        = done_q;
  assign host_write_avail = avail_q;
  assign vram_cs          = vcs_q;
  assign vram_we          = vcs_q;
  assign vram_addr        = vaddr_q;
  assign vram_wdata       = vdata_q;
  assign level            = level_q;

endmodule

// File: tb/tb_vblank_write_queue.sv
// Self-checking bench for vblank_write_queue: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_vblank_write_queue;

  localparam int AW    = 13;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          pixel_clk = 1'b0;
  logic          reset_n;
  logic          drain_en;
  logic          host_cs;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          host_done;
  logic          host_write_avail;
  logic          vram_cs;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_wdata;
  logic          vram_done;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  // Reference model: pending entries, host "already acknowledged" flag, VRAM busy.
  logic [AW+DW-1:0] m_q[$];
  logic [AW+DW-1:0] m_wr[$];
  bit               m_acc  = 1'b0;
  bit               m_busy = 1'b0;
  bit               m_done = 1'b0;

  vblank_write_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .pixel_clk        (pixel_clk),
    .reset_n          (reset_n),
    .drain_en         (drain_en),
    .host_cs          (host_cs),
    .host_addr        (host_addr),
    .host_data        (host_data),
    .host_done        (host_done),
    .host_write_avail (host_write_avail),
    .vram_cs          (vram_cs),
    .vram_we          (vram_we),
    .vram_addr        (vram_addr),
    .vram_wdata       (vram_wdata),
    .vram_done        (vram_done),
    .level            (level)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic model_clear();
    m_q.delete();
    m_acc  = 1'b0;
    m_busy = 1'b0;
    m_done = 1'b0;
  endtask

  // Advance one clock: update the model from the inputs seen at the rising edge,
  // then return at the falling edge where outputs are sampled and inputs driven.
  task automatic tick();
    bit push, pop, busy_n;
    @(posedge pixel_clk);
    if (!reset_n) begin
      model_clear();
    end else begin
      push = host_cs && !m_acc && (m_q.size() < DEPTH);
      pop  = m_busy && vram_done;
      if (!m_busy)        busy_n = drain_en && (m_q.size() > 0);
      else if (vram_done) busy_n = drain_en && (m_q.size() > 1);
      else                busy_n = 1'b1;
      m_acc  = push ? 1'b1 : (host_cs ? m_acc : 1'b0);
      m_done = push;
      if (pop)  m_wr.push_back(m_q.pop_front());
      if (push) m_q.push_back({host_addr, host_data});
      m_busy = busy_n;
    end
    @(negedge pixel_clk);
  endtask

  task automatic push_entry(input logic [AW-1:0] a, input logic [DW-1:0] d, output bit ok);
    ok        = 1'b0;
    host_cs   = 1'b1;
    host_addr = a;
    host_data = d;
    for (int c = 0; c < 8 && !ok; c++) begin
      tick();
      if (host_done === 1'b1) ok = 1'b1;
    end
    host_cs = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b1; drain_en = 1'b0; host_cs = 1'b0;
    host_addr = '0; host_data = '0; vram_done = 1'b0;
    #7 reset_n = 1'b0;
    #1;
    checks++; if (vram_cs !== 1'b0) begin errors++; $display("FAIL reset_vram_cs got %b exp 0", vram_cs); end
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL reset_vram_we got %b exp 0", vram_we); end
    checks++; if (host_done !== 1'b0) begin errors++; $display("FAIL reset_host_done got %b exp 0", host_done); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (host_write_avail !== 1'b1) begin errors++; $display("FAIL reset_avail got %b exp 1", host_write_avail); end
    checks++; if (vram_addr !== 13'h0000) begin errors++; $display("FAIL reset_vram_addr got %h exp 0", vram_addr); end
    checks++; if (vram_wdata !== 16'h0000) begin errors++; $display("FAIL reset_vram_wdata got %h exp 0", vram_wdata); end
    // Request already pending at release: accepted on the first edge after it.
    host_cs = 1'b1; host_addr = 13'h0010; host_data = 16'hAAAA;
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    model_clear();
    reset_n = 1'b1;
    tick();
    checks++; if (host_done !== 1'b1) begin errors++; $display("FAIL first_accept_done got %b exp 1", host_done); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL first_accept_level got %0d exp 1", level); end
    host_cs = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    bit cs_seen = 1'b0;
    int pulses;
    drain_en = 1'b0;
    for (int i = 1; i < 4; i++) begin
      host_cs = 1'b1; host_addr = 13'h0010 + 13'(i); host_data = 16'hAAAA + 16'(i);
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (vram_cs !== 1'b0) cs_seen = 1'b1;
        checks++; if (host_done !== m_done) begin errors++; $display("FAIL fill_done got %b exp %b", host_done, m_done); end
        if (host_done === 1'b1) begin pulses++; host_cs = 1'b0; end
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL fill_pulses got %0d exp 1", pulses); end
    end
    checks++; if (cs_seen) begin errors++; $display("FAIL fill_vram_cs got 1 exp 0"); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level got %0d exp 4", level); end
    checks++; if (host_write_avail !== 1'b0) begin errors++; $display("FAIL fill_avail got %b exp 0", host_write_avail); end
  endtask

  task automatic test_stall_drain();
    logic [AW+DW-1:0] got[$];
    logic [AW+DW-1:0] exp_e;
    int accepted = 0;
    host_cs = 1'b1; host_addr = 13'h0020; host_data = 16'h5555;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (host_done !== 1'b0 || level !== 3'd4) begin errors++; $display("FAIL stall got done=%b level=%0d exp done=0 level=4", host_done, level); end
    end
    drain_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      vram_done = vram_cs && !vram_done;
      if (vram_done) got.push_back({vram_addr, vram_wdata});
      tick();
      if (host_done === 1'b1) begin accepted++; host_cs = 1'b0; end
      checks++; if (vram_cs !== m_busy) begin errors++; $display("FAIL drain_cs got %b exp %b", vram_cs, m_busy); end
      checks++; if (host_done !== m_done) begin errors++; $display("FAIL drain_done got %b exp %b", host_done, m_done); end
      checks++; if (level !== LW'(m_q.size())) begin errors++; $display("FAIL drain_level got %0d exp %0d", level, m_q.size()); end
      if (m_busy) begin
        checks++; if ({vram_addr, vram_wdata} !== m_q[0]) begin errors++; $display("FAIL drain_entry got %h exp %h", {vram_addr, vram_wdata}, m_q[0]); end
      end
    end
    vram_done = 1'b0; drain_en = 1'b0;
    tick();
    checks++; if (accepted != 1) begin errors++; $display("FAIL stall_accepts got %0d exp 1", accepted); end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL drain_count got %0d exp 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      exp_e = (i < 4) ? {13'h0010 + 13'(i), 16'hAAAA + 16'(i)} : {13'h0020, 16'h5555};
      checks++; if (got[i] !== exp_e) begin errors++; $display("FAIL drain_order[%0d] got %h exp %h", i, got[i], exp_e); end
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL drain_final_level got %0d exp 0", level); end
  endtask

  task automatic test_hold_cs(output logic [AW+DW-1:0] ent);
    int pulses = 0;
    drain_en = 1'b0;
    host_cs = 1'b1; host_addr = AW'($urandom); host_data = DW'($urandom);
    ent = {host_addr, host_data};
    for (int c = 0; c < 10; c++) begin
      tick();
      if (host_done === 1'b1) pulses++;
    end
    host_cs = 1'b0;
    tick();
    checks++; if (pulses != 1) begin errors++; $display("FAIL hold_pulses got %0d exp 1", pulses); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL hold_level got %0d exp 1", level); end
  endtask

  task automatic test_drain_short(input logic [AW+DW-1:0] first);
    bit ok, held_bad = 1'b0, idle_bad = 1'b0;
    push_entry(AW'($urandom), DW'($urandom), ok);
    checks++; if (!ok) begin errors++; $display("FAIL short_push got 0 exp 1"); end
    drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    if (vram_cs !== 1'b1 || {vram_addr, vram_wdata} !== first) held_bad = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (vram_cs !== 1'b1 || {vram_addr, vram_wdata} !== first) held_bad = 1'b1;
    end
    checks++; if (held_bad) begin errors++; $display("FAIL short_hold got cs=%b entry=%h exp cs=1 entry=%h", vram_cs, {vram_addr, vram_wdata}, first); end
    vram_done = 1'b1;
    tick();
    vram_done = 1'b0;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL short_level got %0d exp 1", level); end
    for (int c = 0; c < 4; c++) begin
      if (vram_cs !== 1'b0) idle_bad = 1'b1;
      tick();
    end
    checks++; if (idle_bad) begin errors++; $display("FAIL short_idle got vram_cs=1 exp 0"); end
  endtask

  task automatic test_reset_mid_write();
    bit ok, act = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_entry(AW'($urandom), DW'($urandom), ok);
      checks++; if (!ok) begin errors++; $display("FAIL rst_push got 0 exp 1"); end
    end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL rst_pre_level got %0d exp 3", level); end
    drain_en = 1'b1;
    tick();
    tick();
    checks++; if (vram_cs !== 1'b1) begin errors++; $display("FAIL rst_pre_cs got %b exp 1", vram_cs); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (vram_cs !== 1'b0 || vram_we !== 1'b0) begin errors++; $display("FAIL rst_mid_cs got cs=%b we=%b exp 0", vram_cs, vram_we); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_mid_level got %0d exp 0", level); end
    checks++; if (host_write_avail !== 1'b1) begin errors++; $display("FAIL rst_mid_avail got %b exp 1", host_write_avail); end
    @(negedge pixel_clk);
    model_clear();
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      vram_done = 1'($urandom_range(1, 0));
      tick();
      if (vram_cs !== 1'b0) act = 1'b1;
    end
    vram_done = 1'b0;
    checks++; if (act) begin errors++; $display("FAIL rst_after_activity got vram_cs=1 exp 0"); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_after_level got %0d exp 0", level); end
  endtask

  task automatic test_back_to_back();
    logic [AW+DW-1:0] exp_l[$];
    logic [AW+DW-1:0] got[$];
    bit ok;
    drain_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_l.push_back({AW'($urandom), DW'($urandom)});
      push_entry(exp_l[i][AW+DW-1:DW], exp_l[i][DW-1:0], ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_push got 0 exp 1"); end
    end
    drain_en = 1'b1;
    tick();
    exp_l.push_back({AW'($urandom), DW'($urandom)});
    host_cs = 1'b1; {host_addr, host_data} = exp_l[2];
    vram_done = 1'b1;
    got.push_back({vram_addr, vram_wdata});
    tick();
    host_cs = 1'b0;
    checks++; if (host_done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", host_done); end
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_level got %0d exp 2", level); end
    for (int c = 0; c < 20; c++) begin
      vram_done = vram_cs && !vram_done;
      if (vram_done) got.push_back({vram_addr, vram_wdata});
      tick();
    end
    vram_done = 1'b0; drain_en = 1'b0;
    tick();
    checks++; if (got.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_l[i]) begin errors++; $display("FAIL b2b_order[%0d] got %h exp %h", i, got[i], exp_l[i]); end
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_final_level got %0d exp 0", level); end
  endtask

  task automatic test_random();
    bit h_wait = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (host_cs) begin
        if (h_wait && host_done === 1'b1) h_wait = 1'b0;
        if (!h_wait && $urandom_range(1, 0) == 1) host_cs = 1'b0;
      end else if ($urandom_range(1, 0) == 1) begin
        host_cs = 1'b1; h_wait = 1'b1;
        host_addr = AW'($urandom); host_data = DW'($urandom);
      end
      if ($urandom_range(7, 0) == 0) drain_en = ~drain_en;
      vram_done = ($urandom_range(2, 0) == 0);
      tick();
      checks++; if (vram_cs !== m_busy || vram_we !== m_busy) begin errors++; $display("FAIL rnd_cs got cs=%b we=%b exp %b", vram_cs, vram_we, m_busy); end
      checks++; if (host_done !== m_done) begin errors++; $display("FAIL rnd_done got %b exp %b", host_done, m_done); end
      checks++; if (level !== LW'(m_q.size())) begin errors++; $display("FAIL rnd_level got %0d exp %0d", level, m_q.size()); end
      checks++; if (host_write_avail !== (m_q.size() < DEPTH)) begin errors++; $display("FAIL rnd_avail got %b exp %b", host_write_avail, m_q.size() < DEPTH); end
      if (m_busy) begin
        checks++; if ({vram_addr, vram_wdata} !== m_q[0]) begin errors++; $display("FAIL rnd_entry got %h exp %h", {vram_addr, vram_wdata}, m_q[0]); end
      end
    end
    host_cs = 1'b0; vram_done = 1'b0; drain_en = 1'b0;
    tick();
  endtask

  initial begin
    logic [AW+DW-1:0] ent_a;
    test_reset();
    test_fill();
    test_stall_drain();
    test_hold_cs(ent_a);
    test_drain_short(ent_a);
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
